// File: rtl/lfsr_prbs_gen_pkg.sv
// -----------------------------------------------------------------------------
// Package: lfsr_pkg
//
// Purpose
//   Shared definitions for the LFSR pseudo-random generators. The single-channel
//   generator and the later multi-channel generators use it.
//
// Contents
//   MAX_LFSR_WIDTH  widest LFSR any generator in this family supports
//   lfsr_word_t     container wide enough for any supported LFSR state
//   default_taps()  primitive feedback mask for a given width (3..16)
//
// Tap mask encoding: bit i set means stage i+1 feeds the XOR. The state
// shifts toward the MSB and the feedback bit enters at bit 0.
// -----------------------------------------------------------------------------
package lfsr_pkg;

    localparam int MAX_LFSR_WIDTH = 16;

    typedef logic [MAX_LFSR_WIDTH-1:0] lfsr_word_t;

    // Each mask is a primitive polynomial, so any non-zero seed walks through
    // all 2^width-1 non-zero states before repeating. Width 7 uses
    // x^7+x^3+1 so the default generator matches the historic lab sequence.
    // Unsupported widths return 0, which produces no feedback at all and
    // shows up quickly on a bench.
    function automatic lfsr_word_t default_taps(input int width);
        lfsr_word_t taps;
        case (width)
            3:       taps = 16'h0006;
            4:       taps = 16'h000C;
            5:       taps = 16'h0014;
            6:       taps = 16'h0030;
            7:       taps = 16'h0044;
            8:       taps = 16'h00B8;
            9:       taps = 16'h0110;
            10:      taps = 16'h0240;
            11:      taps = 16'h0500;
            12:      taps = 16'h0829;
            13:      taps = 16'h100D;
            14:      taps = 16'h2015;
            15:      taps = 16'h6000;
            16:      taps = 16'hD008;
            default: taps = 16'h0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/lfsr_prbs_gen_step.sv
// -----------------------------------------------------------------------------
// Module: lfsr_step
//
// Purpose
//   Purely combinational single step of a Fibonacci LFSR. The feedback bit is
//   the XOR of the tapped stages. The next state is the current state shifted
//   one place toward the MSB with the feedback bit inserted at bit 0.
//   The multi-channel generators use this block too, so it holds no registers.
//
// Parameters
//   WIDTH  LFSR length in bits
//   TAPS   feedback mask (bit i set => stage i+1 tapped)
//
// Ports
//   state       in   WIDTH  current LFSR state
//   next_state  out  WIDTH  state after one step
// -----------------------------------------------------------------------------
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next_state
);

    logic feedback;

    // The parity of the masked state is the new bit. The MSB drops out of the
    // register during the shift.
    assign feedback   = ^(state & TAPS);
    assign next_state = {state[WIDTH-2:0], feedback};

endmodule

// File: rtl/lfsr_prbs_gen.sv
// -----------------------------------------------------------------------------
// Module: lfsr_prbs_gen
//
// Purpose
//   Parametrised Fibonacci LFSR pseudo-random generator. It supports a runtime
//   seed load and measures the sequence period. Each time the sequence returns
//   to its reference seed, the module pulses wrap and reports the number of
//   steps that period took.
//
// Parameters
//   WIDTH  LFSR length in bits (3..16)
//   TAPS   feedback mask (bit i set => stage i+1 tapped), default x^7+x^3+1
//   SEED   reset/recovery state, must be non-zero
//
// Ports
//   clk           in   1      clock, rising edge
//   rst_n         in   1      asynchronous reset, active low
//   en            in   1      advance one step this cycle
//   load          in   1      load seed_in this cycle (wins over en)
//   seed_in       in   WIDTH  runtime seed
//   data_out      out  WIDTH  current LFSR state
//   bit_out       out  1      MSB of the state (next bit shifted out)
//   wrap          out  1      one-cycle pulse: state returned to reference seed
//   period_out    out  WIDTH  step count of the last completed period
//   period_valid  out  1      period_out holds a valid measurement
//   lockup        out  1      state is all-zero (only with the macro below)
//
// Configuration macro
//   LFSR_LOCKUP_RECOVER_EN
//     Defined:   a zero seed is loaded as-is. lockup flags the stuck state,
//                and the next enabled step restores SEED.
//     Undefined: a zero seed is replaced by SEED on load, and lockup is
//                tied to 0.
// -----------------------------------------------------------------------------
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] data_out,
    output logic             bit_out,
    output logic             wrap,
    output logic [WIDTH-1:0] period_out,
    output logic             period_valid,
    output logic             lockup
);

    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] ref_state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] load_value;
    logic             in_lockup;
    logic             ref_hit;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .state      (state),
        .next_state (next_state)
    );

    assign data_out = state;
    assign bit_out  = state[WIDTH-1];

    // Compare against the state being produced, not the current one. This
    // way the wrap pulse appears together with the returned state on
    // data_out.
    assign ref_hit = (next_state == ref_state);

`ifdef LFSR_LOCKUP_RECOVER_EN
    // A zero seed is accepted so that software can test the recovery path.
    // While the state is zero, the next enabled step restores SEED instead of
    // shifting, because shifting zero would keep it zero forever.
    assign load_value = seed_in;
    assign in_lockup  = (state == '0);

    // lockup mirrors "state is zero". It changes only on the cycles that can
    // change the state: a load sets or clears it from the seed, and an
    // enabled step always leaves a non-zero state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lockup <= 1'b0;
        end else if (load) begin
            lockup <= (seed_in == '0);
        end else if (en) begin
            lockup <= 1'b0;
        end
    end
`else
    // Without recovery logic, a zero seed must never reach the register.
    // Loading SEED instead keeps the generator running.
    assign load_value = (seed_in == '0) ? SEED : seed_in;
    assign in_lockup  = 1'b0;
    assign lockup     = 1'b0;
`endif

    // Main state, reference and period bookkeeping. The wrap flag clears by
    // default every cycle, which keeps it a single-cycle pulse even when en
    // drops right after a wrap. The other registers hold unless loaded or
    // stepped. cnt counts steps since the last reference match. On a match,
    // the completed period is cnt+1, because the matching step itself counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SEED;
            ref_state    <= SEED;
            cnt          <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            wrap         <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                state        <= load_value;
                ref_state    <= load_value;
                cnt          <= '0;
                period_valid <= 1'b0;
            end else if (en) begin
                if (in_lockup) begin
                    state     <= SEED;
                    ref_state <= SEED;
                    cnt       <= '0;
                end else begin
                    state <= next_state;
                    if (ref_hit) begin
                        wrap         <= 1'b1;
                        period_out   <= cnt + WIDTH'(1);
                        period_valid <= 1'b1;
                        cnt          <= '0;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// -----------------------------------------------------------------------------
// Testbench: tb_lfsr_prbs_gen
//
// Instance dut_a uses the default 7-bit generator (x^7+x^3+1). Instance dut_b
// is a 4-bit generator (TAPS=4'hC). Both are compared every cycle against a
// reference model.
//
// The model does not track a shift register. For each reference seed it
// precomputes the orbit (the list of states visited until the sequence
// returns to the seed). It then tracks only how many steps have passed since
// the reference. The expected state is orbit[steps], and a wrap is expected
// when steps reaches the orbit length.
// -----------------------------------------------------------------------------
module tb_lfsr_prbs_gen;

    logic       clk;
    logic       rst_n;

    logic       en_a, load_a;
    logic [6:0] seed_a;
    logic [6:0] data_a, period_a;
    logic       bit_a, wrap_a, pvalid_a, lockup_a;

    logic       en_b, load_b;
    logic [3:0] seed_b;
    logic [3:0] data_b, period_b;
    logic       bit_b, wrap_b, pvalid_b, lockup_b;

    int cmp_count  = 0;
    int fail_count = 0;

    // Reference model, indexed by channel (0 = dut_a, 1 = dut_b).
    int m_w[2];
    int m_taps[2];
    int m_seed[2];
    int orbit[2][0:255];
    int m_per[2];
    int m_ref[2];
    int m_steps[2];
    int m_pout[2];
    bit m_pval[2];
    bit m_wrap[2];
    bit m_lock[2];

    lfsr_prbs_gen #(.WIDTH(7), .TAPS(7'h44), .SEED(7'd1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .load(load_a), .seed_in(seed_a),
        .data_out(data_a), .bit_out(bit_a), .wrap(wrap_a),
        .period_out(period_a), .period_valid(pvalid_a), .lockup(lockup_a)
    );

    lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'd1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .load(load_b), .seed_in(seed_b),
        .data_out(data_b), .bit_out(bit_b), .wrap(wrap_b),
        .period_out(period_b), .period_valid(pvalid_b), .lockup(lockup_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always ends even if the flow below stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Count the comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        cmp_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Apply one LFSR step as a plain shift-and-parity rule on integers.
    function automatic int nextState(input int s, input int w, input int taps);
        return ((s << 1) & ((1 << w) - 1)) | ($countones(s & taps) & 1);
    endfunction

    // Walk from the reference seed until it comes back. The number of states
    // visited is the period.
    task automatic buildOrbit(input int ch);
        int s;
        int n;
        orbit[ch][0] = m_ref[ch];
        s = nextState(m_ref[ch], m_w[ch], m_taps[ch]);
        n = 1;
        while (s != m_ref[ch] && n < 256) begin
            orbit[ch][n] = s;
            s = nextState(s, m_w[ch], m_taps[ch]);
            n++;
        end
        m_per[ch] = n;
    endtask

    task automatic modelReset();
        for (int ch = 0; ch < 2; ch++) begin
            m_ref[ch]   = m_seed[ch];
            m_steps[ch] = 0;
            m_pout[ch]  = 0;
            m_pval[ch]  = 1'b0;
            m_wrap[ch]  = 1'b0;
            m_lock[ch]  = 1'b0;
            buildOrbit(ch);
        end
    endtask

    task automatic modelCycle(input int ch, input bit ld, input bit e, input int sd);
        m_wrap[ch] = 1'b0;
        if (ld) begin
            m_steps[ch] = 0;
            m_pval[ch]  = 1'b0;
            if (sd == 0) begin
`ifdef LFSR_LOCKUP_RECOVER_EN
                m_lock[ch] = 1'b1;
                m_ref[ch]  = 0;
`else
                m_lock[ch] = 1'b0;
                m_ref[ch]  = m_seed[ch];
`endif
            end else begin
                m_lock[ch] = 1'b0;
                m_ref[ch]  = sd;
            end
            if (!m_lock[ch]) buildOrbit(ch);
        end else if (e) begin
            if (m_lock[ch]) begin
                m_lock[ch]  = 1'b0;
                m_ref[ch]   = m_seed[ch];
                m_steps[ch] = 0;
                buildOrbit(ch);
            end else begin
                m_steps[ch]++;
                if (m_steps[ch] == m_per[ch]) begin
                    m_wrap[ch]  = 1'b1;
                    m_pout[ch]  = m_per[ch];
                    m_pval[ch]  = 1'b1;
                    m_steps[ch] = 0;
                end
            end
        end
    endtask

    task automatic checkChannel(input int ch);
        int exp_data;
        exp_data = m_lock[ch] ? 0 : orbit[ch][m_steps[ch]];
        if (ch == 0) begin
            checkOutput("a.data",   int'(data_a),   exp_data);
            checkOutput("a.bit",    int'(bit_a),    (exp_data >> 6) & 1);
            checkOutput("a.wrap",   int'(wrap_a),   int'(m_wrap[0]));
            checkOutput("a.period", int'(period_a), m_pout[0]);
            checkOutput("a.pvalid", int'(pvalid_a), int'(m_pval[0]));
            checkOutput("a.lockup", int'(lockup_a), int'(m_lock[0]));
        end else begin
            checkOutput("b.data",   int'(data_b),   exp_data);
            checkOutput("b.bit",    int'(bit_b),    (exp_data >> 3) & 1);
            checkOutput("b.wrap",   int'(wrap_b),   int'(m_wrap[1]));
            checkOutput("b.period", int'(period_b), m_pout[1]);
            checkOutput("b.pvalid", int'(pvalid_b), int'(m_pval[1]));
            checkOutput("b.lockup", int'(lockup_b), int'(m_lock[1]));
        end
    endtask

    // Drive one cycle of inputs. Call this just after a rising edge. It waits
    // for the next edge, advances the model and checks both DUTs.
    task automatic applyStimulus(input bit ld_a, input bit e_a, input int sd_a, input bit e_b);
        int sd_v;
        sd_v   = sd_a;
        load_a = ld_a;
        en_a   = e_a;
        seed_a = sd_v[6:0];
        en_b   = e_b;
        load_b = 1'b0;
        seed_b = 4'd0;
        @(posedge clk);
        #1;
        modelCycle(0, ld_a, e_a, sd_a);
        modelCycle(1, 1'b0, e_b, 0);
        checkChannel(0);
        checkChannel(1);
    endtask

    task automatic idleInputs();
        en_a   = 1'b0;
        load_a = 1'b0;
        seed_a = 7'd0;
        en_b   = 1'b0;
        load_b = 1'b0;
        seed_b = 4'd0;
    endtask

    initial begin
        int first_vals[4];
        int wraps;
        int sd;
        bit ld, e, eb;

        first_vals[0] = 2; first_vals[1] = 4; first_vals[2] = 9; first_vals[3] = 18;

        m_w[0] = 7; m_taps[0] = 'h44; m_seed[0] = 1;
        m_w[1] = 4; m_taps[1] = 'hC;  m_seed[1] = 1;

        // Reset state.
        idleInputs();
        rst_n = 1'b0;
        #12;
        modelReset();
        checkChannel(0);
        checkChannel(1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Default generator free-running for one full period.
        for (int i = 0; i < 127; i++) begin
            applyStimulus(1'b0, 1'b1, 0, 1'b0);
            if (i < 4) checkOutput("t1.seq", int'(data_a), first_vals[i]);
        end
        checkOutput("t1.wrap",   int'(wrap_a),   1);
        checkOutput("t1.data",   int'(data_a),   1);
        checkOutput("t1.period", int'(period_a), 127);
        checkOutput("t1.pvalid", int'(pvalid_a), 1);
        applyStimulus(1'b0, 1'b0, 0, 1'b0);

        // en toggled every cycle: 254 cycles give 127 steps and one wrap.
        wraps = 0;
        for (int i = 0; i < 254; i++) begin
            applyStimulus(1'b0, (i % 2) == 0, 0, 1'b0);
            wraps += int'(wrap_a);
        end
        checkOutput("t2.wraps", wraps, 1);
        checkOutput("t2.data",  int'(data_a), 1);

        // Load wins over en. The loaded seed becomes the new reference.
        applyStimulus(1'b1, 1'b1, 'h55, 1'b0);
        checkOutput("t3.load_data",   int'(data_a),   'h55);
        checkOutput("t3.load_pvalid", int'(pvalid_a), 0);
        for (int i = 0; i < 127; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0);
        checkOutput("t3.wrap", int'(wrap_a), 1);
        checkOutput("t3.data", int'(data_a), 'h55);

        // Asynchronous reset between edges while a wrap pulse is showing.
        idleInputs();
        #3;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput("t4.data",   int'(data_a),   1);
        checkOutput("t4.wrap",   int'(wrap_a),   0);
        checkOutput("t4.pvalid", int'(pvalid_a), 0);
        checkOutput("t4.period", int'(period_a), 0);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 127; i++) applyStimulus(1'b0, 1'b1, 0, 1'b0);
        checkOutput("t4.rewrap", int'(wrap_a), 1);

        // Zero seed handling.
        applyStimulus(1'b1, 1'b0, 0, 1'b0);
`ifdef LFSR_LOCKUP_RECOVER_EN
        checkOutput("t5.lock_data", int'(data_a),   0);
        checkOutput("t5.lockup",    int'(lockup_a), 1);
        applyStimulus(1'b0, 1'b1, 0, 1'b0);
        checkOutput("t5.recover",   int'(data_a),   1);
        checkOutput("t5.unlock",    int'(lockup_a), 0);
`else
        checkOutput("t5.zero_data", int'(data_a),   1);
        checkOutput("t5.lockup",    int'(lockup_a), 0);
        applyStimulus(1'b0, 1'b1, 0, 1'b0);
        checkOutput("t5.step",      int'(data_a),   2);
`endif

        // 4-bit generator: 60 steps give four 15-step periods.
        wraps = 0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(1'b0, 1'b0, 0, 1'b1);
            wraps += int'(wrap_b);
        end
        checkOutput("t6.wraps",  wraps, 4);
        checkOutput("t6.period", int'(period_b), 15);
        checkOutput("t6.wrap",   int'(wrap_b),   1);

        // Randomised mix of steps, holds and loads, zero seeds included.
        for (int i = 0; i < 1500; i++) begin
            ld = ($urandom_range(0, 15) == 0);
            e  = ($urandom_range(0, 3) != 0);
            eb = ($urandom_range(0, 1) == 1);
            sd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
            applyStimulus(ld, e, sd, eb);
        end

        idleInputs();
        $display("End of test - %0d assertions evaluated, %0d failures", cmp_count, fail_count);
        $finish;
    end

endmodule
